// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus UART transmit/receive side-band signals of the memory/I-O responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// Single-cycle memory responder: byte RAM, UART TX FIFO / RX port, cycle counter and stop flag
// behind a fixed I/O window at 0x30000.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  mem_io_responder_if.slave bus
);
  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C  = (PW+1)'(TX_DEPTH);
  localparam logic [PW:0] NEAR_C   = (PW+1)'(TX_DEPTH - 1);

  logic [7:0]  ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0]  fifo_r [0:TX_DEPTH-1];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW:0]   count_r, count_nxt_s;
  logic [31:0] cycle_cnt_r, snap_r;
  logic [7:0]  ram_q_r, io_q_r, io_rd_data_s, push_data_s;
  logic        sel_ram_r, stop_r, full_r;
  logic        is_io_s, rd_s, push_s, pop_s, accept_s;
  logic [17:0] io_addr_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;

  assign io_addr_s  = bus.mem_a[17:0];
  assign is_io_s    = (bus.mem_a[17:16] == 2'b11);
  assign rd_s       = ~bus.mem_wr;
  assign ram_addr_s = bus.mem_a[ADDR_WIDTH-1:0];

  // Access decode: TX push source, I/O read data and FIFO occupancy update.
  always_comb begin
    push_s       = 1'b0;
    push_data_s  = 8'h00;
    io_rd_data_s = 8'h00;
    if (bus.mem_wr && (io_addr_s == 18'h30000)) begin
      push_s      = (bus.mem_dout != 8'h00);
      push_data_s = bus.mem_dout;
    end else if (bus.mem_wr && (io_addr_s == 18'h30004)) begin
      push_s      = 1'b1;
      push_data_s = 8'h00;
    end else begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
    end
    case (io_addr_s)
      18'h30000: io_rd_data_s = bus.rx_valid ? bus.rx_data : 8'h00;
      18'h30004: io_rd_data_s = cycle_cnt_r[7:0];
      18'h30005: io_rd_data_s = snap_r[15:8];
      18'h30006: io_rd_data_s = snap_r[23:16];
      18'h30007: io_rd_data_s = snap_r[31:24];
      default:   io_rd_data_s = 8'h00;
    endcase
    pop_s    = (count_r != {(PW+1){1'b0}}) && bus.tx_ready;
    accept_s = push_s && ((count_r != DEPTH_C) || pop_s);
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{PW{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{PW{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage without reset: RAM array, its read register and the FIFO byte slots.
  always_ff @(posedge clk_in) begin
    if (bus.mem_wr && !is_io_s) begin
      ram[ram_addr_s] <= bus.mem_dout;
    end
    ram_q_r <= ram[ram_addr_s];
    if (accept_s) begin
      fifo_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Control state: read-return select, counter/snapshot, FIFO pointers, status flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_ram_r   <= 1'b0;
      io_q_r      <= 8'h00;
      cycle_cnt_r <= 32'h0000_0000;
      snap_r      <= 32'h0000_0000;
      stop_r      <= 1'b0;
      full_r      <= 1'b0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {(PW+1){1'b0}};
    end else begin
      sel_ram_r   <= rd_s && !is_io_s;
      io_q_r      <= (rd_s && is_io_s) ? io_rd_data_s : 8'h00;
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if (rd_s && (io_addr_s == 18'h30004)) begin
        snap_r <= cycle_cnt_r;
      end
      if (bus.mem_wr && (io_addr_s == 18'h30004)) begin
        stop_r <= 1'b1;
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s >= NEAR_C);
    end
  end

  // rx_pop is a pure function of inputs so the receive queue advances in the read cycle itself.
  assign bus.rx_pop         = ~rst_in & rd_s & (io_addr_s == 18'h30000) & bus.rx_valid;
  assign bus.mem_din        = sel_ram_r ? ram_q_r : io_q_r;
  assign bus.tx_data        = fifo_r[rd_ptr_r];
  assign bus.tx_valid       = (count_r != {(PW+1){1'b0}});
  assign bus.io_buffer_full = full_r;
  assign bus.program_stop   = stop_r;
endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized self-checking bench for mem_io_responder against a transaction-level model.
module tb_mem_io_responder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_io_responder_if bus();
  mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  tx_q [$];
  logic        stop_m = 1'b0;
  logic [31:0] cnt_m = 32'd0;
  logic [31:0] snap_m = 32'd0;
  logic [7:0]  exp_din = 8'h00;
  bit          din_known = 1'b0;
  logic        last_pop = 1'b0;
  logic        exp_pop = 1'b0;

  // One bus cycle: drive inputs, capture rx_pop, advance model, step the clock.
  task automatic do_cycle(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic rdy);
    logic [17:0] ia;
    logic push;
    logic [7:0] pd;
    bus.mem_wr = wr; bus.mem_a = a; bus.mem_dout = d; bus.tx_ready = rdy;
    #1;
    ia = a[17:0];
    last_pop = bus.rx_pop;
    exp_pop = !wr && (ia == 18'h30000) && bus.rx_valid;
    push = 1'b0; pd = 8'h00; din_known = 1'b1; exp_din = 8'h00;
    if (wr) begin
      if (ia[17:16] != 2'b11) ram_m[int'(a[16:0])] = d;
      else if (ia == 18'h30000 && d != 8'h00) begin push = 1'b1; pd = d; end
      else if (ia == 18'h30004) begin push = 1'b1; stop_m = 1'b1; end
    end else if (ia[17:16] != 2'b11) begin
      if (ram_m.exists(int'(a[16:0]))) exp_din = ram_m[int'(a[16:0])];
      else din_known = 1'b0;
    end else begin
      case (ia)
        18'h30000: exp_din = bus.rx_valid ? bus.rx_data : 8'h00;
        18'h30004: begin exp_din = cnt_m[7:0]; snap_m = cnt_m; end
        18'h30005: exp_din = snap_m[15:8];
        18'h30006: exp_din = snap_m[23:16];
        18'h30007: exp_din = snap_m[31:24];
        default:   exp_din = 8'h00;
      endcase
    end
    if (tx_q.size() > 0 && rdy) void'(tx_q.pop_front());
    if (push && tx_q.size() < DEPTH) tx_q.push_back(pd);
    cnt_m = cnt_m + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    bus.mem_wr = 1'b0; bus.mem_a = 32'h0003_0000; bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    #1;
    n_total++; if (bus.mem_din !== 8'h00) $display("FAIL reset_mem_din: got %h expected 00", bus.mem_din); else n_pass++;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.io_buffer_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.io_buffer_full); else n_pass++;
    n_total++; if (bus.program_stop !== 1'b0) $display("FAIL reset_stop: got %b expected 0", bus.program_stop); else n_pass++;
    n_total++; if (bus.rx_pop !== 1'b0) $display("FAIL reset_rx_pop: got %b expected 0", bus.rx_pop); else n_pass++;
    tx_q.delete(); stop_m = 1'b0; cnt_m = 32'd0; snap_m = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; bus.rx_valid = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] a;
    do_cycle(1'b1, 32'h0000_0010, 8'hA5, 1'b0);
    n_total++; if (bus.mem_din !== 8'h00) $display("FAIL ram_after_write: got %h expected 00", bus.mem_din); else n_pass++;
    do_cycle(1'b0, 32'h0000_0010, 8'h00, 1'b0);
    n_total++; if (bus.mem_din !== 8'hA5) $display("FAIL ram_readback: got %h expected a5", bus.mem_din); else n_pass++;
    for (int i = 0; i < 80; i++) begin
      a = {14'd0, 2'($urandom_range(0, 2)), 12'h000, 4'($urandom_range(0, 15))};
      do_cycle(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0);
      if (din_known) begin
        n_total++;
        if (bus.mem_din !== exp_din) $display("FAIL ram_random @%h: got %h expected %h", a, bus.mem_din, exp_din);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ram_survives_reset();
    do_cycle(1'b1, 32'h0000_0123, 8'h55, 1'b0);
    test_reset();
    do_cycle(1'b0, 32'h0000_0123, 8'h00, 1'b0);
    n_total++; if (bus.mem_din !== 8'h55) $display("FAIL ram_after_reset: got %h expected 55", bus.mem_din); else n_pass++;
  endtask

  task automatic test_tx_basic();
    logic [7:0] got_q [$];
    do_cycle(1'b1, 32'h0003_0000, 8'h48, 1'b0);
    do_cycle(1'b1, 32'h0003_0000, 8'h69, 1'b0);
    do_cycle(1'b1, 32'h0003_0000, 8'h00, 1'b0);
    n_total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h48)
      $display("FAIL tx_head: got valid=%b data=%h expected valid=1 data=48", bus.tx_valid, bus.tx_data); else n_pass++;
    n_total++; if (bus.io_buffer_full !== 1'b0) $display("FAIL tx_two_not_full: got %b expected 0", bus.io_buffer_full); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_valid === 1'b1) got_q.push_back(bus.tx_data);
      do_cycle(1'b0, 32'h0003_FFF0, 8'h00, 1'b1);
    end
    n_total++; if (got_q.size() != 2 || got_q[0] !== 8'h48 || got_q[1] !== 8'h69)
      $display("FAIL tx_emitted: got %0d bytes expected 2 bytes 48,69", got_q.size()); else n_pass++;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL tx_empty: got %b expected 0", bus.tx_valid); else n_pass++;
  endtask

  task automatic test_tx_full();
    logic [7:0] sent [9];
    logic [7:0] got_q [$];
    for (int i = 0; i < 9; i++) begin
      sent[i] = 8'($urandom_range(1, 255));
      do_cycle(1'b1, 32'h0003_0000, sent[i], 1'b0);
      if (i == 5) begin
        n_total++; if (bus.io_buffer_full !== 1'b0) $display("FAIL full_after6: got %b expected 0", bus.io_buffer_full); else n_pass++;
      end
      if (i == 6) begin
        n_total++; if (bus.io_buffer_full !== 1'b1) $display("FAIL full_after7: got %b expected 1", bus.io_buffer_full); else n_pass++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid === 1'b1) got_q.push_back(bus.tx_data);
      do_cycle(1'b0, 32'h0003_FFF0, 8'h00, 1'b1);
    end
    n_total++; if (got_q.size() != 8) $display("FAIL full_drain_count: got %0d expected 8", got_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== sent[i]) $display("FAIL full_order[%0d]: got %h expected %h", i, got_q[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_counter();
    logic [7:0] want [4];
    want[0] = 8'h64; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h00;
    test_reset();
    for (int i = 0; i < 100; i++) do_cycle(1'b0, 32'h0003_FFF0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 32'h0003_0004 + 32'(i), 8'h00, 1'b0);
      n_total++; if (bus.mem_din !== want[i]) $display("FAIL counter_byte%0d: got %h expected %h", i, bus.mem_din, want[i]); else n_pass++;
    end
  endtask

  task automatic test_rx();
    bus.rx_valid = 1'b1; bus.rx_data = 8'h37;
    do_cycle(1'b0, 32'h0003_0000, 8'h00, 1'b0);
    n_total++; if (last_pop !== 1'b1) $display("FAIL rx_pop_high: got %b expected 1", last_pop); else n_pass++;
    n_total++; if (bus.mem_din !== 8'h37) $display("FAIL rx_data: got %h expected 37", bus.mem_din); else n_pass++;
    bus.rx_valid = 1'b0;
    do_cycle(1'b0, 32'h0003_0000, 8'h00, 1'b0);
    n_total++; if (last_pop !== 1'b0) $display("FAIL rx_pop_low: got %b expected 0", last_pop); else n_pass++;
    n_total++; if (bus.mem_din !== 8'h00) $display("FAIL rx_empty: got %h expected 00", bus.mem_din); else n_pass++;
  endtask

  task automatic test_stop_reset();
    do_cycle(1'b1, 32'h0003_0004, 8'h11, 1'b0);
    n_total++; if (bus.program_stop !== 1'b1) $display("FAIL stop_set: got %b expected 1", bus.program_stop); else n_pass++;
    n_total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00)
      $display("FAIL stop_push: got valid=%b data=%h expected valid=1 data=00", bus.tx_valid, bus.tx_data); else n_pass++;
    do_cycle(1'b1, 32'h0003_0000, 8'h41, 1'b0);
    do_cycle(1'b1, 32'h0003_0004, 8'h00, 1'b0);
    n_total++; if (bus.program_stop !== 1'b1) $display("FAIL stop_sticky: got %b expected 1", bus.program_stop); else n_pass++;
    do_cycle(1'b0, 32'h0003_FFF0, 8'h00, 1'b1);
    test_reset();
    do_cycle(1'b0, 32'h0003_FFF0, 8'h00, 1'b1);
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL stop_fifo_discard: got %b expected 0", bus.tx_valid); else n_pass++;
  endtask

  task automatic test_random_mix();
    logic [31:0] a;
    logic wr;
    logic [7:0] d;
    int op;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      bus.rx_valid = 1'($urandom_range(0, 1)); bus.rx_data = 8'($urandom);
      case (op)
        0, 1, 2: begin wr = 1'b1; a = 32'h0003_0000; end
        3:       begin wr = ($urandom_range(0, 15) == 0); a = 32'h0003_0004 + 32'($urandom_range(0, 3)); end
        4:       begin wr = 1'b0; a = 32'h0003_0000; end
        5:       begin wr = 1'($urandom_range(0, 1)); a = 32'h0003_0008 + 32'($urandom_range(0, 64)); end
        default: begin wr = 1'($urandom_range(0, 1)); a = {15'd0, 1'($urandom_range(0, 1)), 12'h0, 4'($urandom)}; end
      endcase
      n_total++;
      if (bus.tx_valid !== (tx_q.size() > 0) || (tx_q.size() > 0 && bus.tx_data !== tx_q[0]))
        $display("FAIL mix_tx_head #%0d: got valid=%b data=%h expected size=%0d", i, bus.tx_valid, bus.tx_data, tx_q.size());
      else n_pass++;
      do_cycle(wr, a, d, 1'($urandom_range(0, 2) == 0));
      n_total++; if (last_pop !== exp_pop) $display("FAIL mix_rx_pop #%0d: got %b expected %b", i, last_pop, exp_pop); else n_pass++;
      if (din_known) begin
        n_total++; if (bus.mem_din !== exp_din) $display("FAIL mix_din #%0d @%h: got %h expected %h", i, a, bus.mem_din, exp_din); else n_pass++;
      end
      n_total++; if (bus.io_buffer_full !== (tx_q.size() >= DEPTH - 1))
        $display("FAIL mix_full #%0d: got %b expected size=%0d", i, bus.io_buffer_full, tx_q.size()); else n_pass++;
      n_total++; if (bus.program_stop !== stop_m) $display("FAIL mix_stop #%0d: got %b expected %b", i, bus.program_stop, stop_m); else n_pass++;
    end
  endtask

  initial begin
    bus.mem_a = 32'd0; bus.mem_dout = 8'h00; bus.mem_wr = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    test_reset();
    test_ram();
    test_ram_survives_reset();
    test_tx_basic();
    test_tx_full();
    test_counter();
    test_rx();
    test_stop_reset();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
